// File: rtl/mul_arbiter.sv
// mul_arbiter: two-port arbiter in front of a shared, external combinational
// 32x32 signed multiplier. An accepted operand pair is registered onto
// mul_p/mul_q, allowed WAIT_CYCLES cycles to settle, and then the result is
// captured into resp_prod and offered with a valid/ready handshake.
//
// Build option: define MUL_ARB_RR_EN to arbitrate round-robin between the
// two ports. Without it, port 0 has fixed priority.
//
// state | meaning
// IDLE  | arbitrating, readies may be high
// WAIT  | operands on mul_p/mul_q, counting down settle cycles
// DONE  | product held on resp_prod until the consumer takes it

module mul_arbiter #(
  parameter int WAIT_CYCLES = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [31:0] req0_a,
  input  logic [31:0] req0_b,
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic [31:0] req1_a,
  input  logic [31:0] req1_b,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic        resp_id,
  output logic [63:0] resp_prod,
  output logic [31:0] mul_p,
  output logic [31:0] mul_q,
  input  logic [63:0] mul_y,
  output logic        busy
);

  typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

  localparam logic [3:0] CNT_LOAD = 4'(WAIT_CYCLES);

  state_t     state, state_nxt;
  logic [3:0] cnt;
  logic       grant_id;
  logic       accept;

`ifdef MUL_ARB_RR_EN
  logic last_id;

  // Round-robin grant: on contention the port not served last wins.
  always_comb begin
    grant_id = 1'b0;
    if (req0_valid && req1_valid) grant_id = ~last_id;
    else if (req1_valid)          grant_id = 1'b1;
  end

  // Remember which port was served most recently.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      last_id <= 1'b1;
    else if (accept) last_id <= grant_id;
  end
`else
  // Fixed-priority grant: port 1 only wins when port 0 is not asking.
  always_comb begin
    grant_id = 1'b0;
    if (!req0_valid && req1_valid) grant_id = 1'b1;
  end
`endif

  assign req0_ready = (state == IDLE) && req0_valid && !grant_id;
  assign req1_ready = (state == IDLE) && req1_valid &&  grant_id;
  assign accept     = req0_ready || req1_ready;
  assign busy       = (state != IDLE);

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = WAIT;
      WAIT:    if (cnt == 4'd1) state_nxt = DONE;
      DONE:    if (resp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Operand capture, settle counter and product/response registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mul_p      <= '0;
      mul_q      <= '0;
      resp_id    <= 1'b0;
      resp_prod  <= '0;
      resp_valid <= 1'b0;
      cnt        <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            mul_p   <= grant_id ? req1_a : req0_a;
            mul_q   <= grant_id ? req1_b : req0_b;
            resp_id <= grant_id;
            cnt     <= CNT_LOAD;
          end
        end
        WAIT: begin
          cnt <= cnt - 4'd1;
          if (cnt == 4'd1) begin
            resp_prod  <= mul_y;
            resp_valid <= 1'b1;
          end
        end
        DONE: begin
          if (resp_ready) resp_valid <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mul_arbiter.sv
// Directed bench for mul_arbiter with a behavioural shared multiplier.
module tb_mul_arbiter;

  localparam int W = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req0_valid, req1_valid;
  logic        req0_ready, req1_ready;
  logic [31:0] req0_a, req0_b, req1_a, req1_b;
  logic        resp_valid, resp_ready, resp_id;
  logic [63:0] resp_prod;
  logic [31:0] mul_p, mul_q;
  logic [63:0] mul_y;
  logic        busy;

  int checks = 0;
  int errors = 0;

  mul_arbiter #(.WAIT_CYCLES(W)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_id(resp_id),
    .resp_prod(resp_prod), .mul_p(mul_p), .mul_q(mul_q), .mul_y(mul_y), .busy(busy)
  );

  // Shared multiplier: sign-extend to 64 bits, low 64 bits are the signed product.
  assign mul_y = {{32{mul_p[31]}}, mul_p} * {{32{mul_q[31]}}, mul_q};

  always #5 clk = ~clk;

  typedef struct {
    logic        port;
    logic [31:0] a;
    logic [31:0] b;
    logic [63:0] prod;
  } vec_t;

  vec_t vecs [7];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_resp(output int lat);
    lat = 0;
    while (!resp_valid && lat < 50) begin
      tick();
      lat++;
    end
  endtask

  task automatic run_txn(input logic port, input logic [31:0] a, input logic [31:0] b,
                         input logic [63:0] exp);
    int lat;
    if (port) begin req1_valid = 1'b1; req1_a = a; req1_b = b; end
    else      begin req0_valid = 1'b1; req0_a = a; req0_b = b; end
    #1;
    chk("grant_ready", {req1_ready, req0_ready}, port ? 64'd2 : 64'd1);
    tick();
    req0_valid = 1'b0; req1_valid = 1'b0;
    req0_a = $urandom; req0_b = $urandom; req1_a = $urandom; req1_b = $urandom;
    chk("busy_after_accept", busy, 1);
    chk("mul_p_latched", mul_p, a);
    wait_resp(lat);
    chk("latency", 64'(lat), 64'(W));
    chk("resp_prod", resp_prod, exp);
    chk("resp_id", resp_id, port);
    resp_ready = 1'b1;
    tick();
    resp_ready = 1'b0;
    chk("resp_valid_cleared", {resp_valid, busy}, 0);
  endtask

  initial begin
    int lat;
    int gcnt;
    int last_cyc;
    logic [3:0]  grants;
    int          gcyc [4];

    vecs[0] = '{1'b0, 32'd7,          32'hFFFFFFFD, 64'hFFFFFFFFFFFFFFEB};
    vecs[1] = '{1'b0, 32'h80000000,   32'h80000000, 64'h4000000000000000};
    vecs[2] = '{1'b1, 32'hFFFFFFFF,   32'hFFFFFFFF, 64'h0000000000000001};
    vecs[3] = '{1'b1, 32'h7FFFFFFF,   32'h7FFFFFFF, 64'h3FFFFFFF00000001};
    vecs[4] = '{1'b0, 32'h7FFFFFFF,   32'h80000000, 64'hC000000080000000};
    vecs[5] = '{1'b1, 32'd12345,      32'd0,        64'h0000000000000000};
    vecs[6] = '{1'b1, 32'hFFFFFF9C,   32'd25,       64'hFFFFFFFFFFFFF63C};

    rst_n = 1'b0;
    req0_valid = 1'b0; req1_valid = 1'b0; resp_ready = 1'b0;
    req0_a = '0; req0_b = '0; req1_a = '0; req1_b = '0;
    #12;
    chk("reset_status", {resp_valid, resp_id, busy, req0_ready, req1_ready}, 0);
    chk("reset_prod", resp_prod, 0);
    chk("reset_operands", {mul_p, mul_q}, 0);
    rst_n = 1'b1;
    tick();
    tick();

    // Table of single transactions.
    for (int i = 0; i < 7; i++) begin
      run_txn(vecs[i].port, vecs[i].a, vecs[i].b, vecs[i].prod);
    end

    // Stall in DONE with both ports waiting, then handshake with req1 pending.
    req0_valid = 1'b1; req0_a = 32'd5; req0_b = 32'd6;
    tick();
    req0_valid = 1'b0;
    req1_valid = 1'b1; req1_a = 32'hFFFFFFF9; req1_b = 32'd9;
    wait_resp(lat);
    chk("stall_latency", 64'(lat), 64'(W));
    for (int c = 0; c < 10; c++) begin
      chk("stall_status", {resp_valid, resp_id, req0_ready, req1_ready, busy}, 64'b10001);
      chk("stall_operands", {mul_p, mul_q}, {32'd5, 32'd6});
      chk("stall_prod", resp_prod, 64'd30);
      tick();
    end
    resp_ready = 1'b1;
    #1;
    chk("req1_ready_on_handshake", req1_ready, 0);
    tick();
    resp_ready = 1'b0;
    chk("after_handshake", {resp_valid, busy, req1_ready}, 64'b001);
    tick();
    req1_valid = 1'b0;
    chk("req1_accepted_next", {busy, resp_id}, 64'b11);
    chk("req1_operand", mul_p, 32'hFFFFFFF9);
    wait_resp(lat);
    chk("req1_latency", 64'(lat), 64'(W));
    chk("req1_prod", resp_prod, 64'hFFFFFFFFFFFFFFC1);
    resp_ready = 1'b1;
    tick();
    resp_ready = 1'b0;

    // Arbitration sequence with both ports permanently valid.
    rst_n = 1'b0;
    #1;
    rst_n = 1'b1;
    req0_valid = 1'b1; req0_a = 32'd2;          req0_b = 32'd3;
    req1_valid = 1'b1; req1_a = 32'hFFFFFFFB;   req1_b = 32'd4;
    resp_ready = 1'b1;
    #1;
    gcnt = 0;
    grants = '0;
    for (int c = 0; c < 100 && gcnt < 4; c++) begin
      if (req0_ready && req1_ready) chk("both_ready", 1, 0);
      if (req0_ready || req1_ready) begin
        grants[gcnt] = req1_ready;
        gcyc[gcnt]   = c;
        gcnt++;
      end
      tick();
    end
    chk("grant_count", 64'(gcnt), 64'd4);
    last_cyc = gcyc[0];
    for (int i = 0; i < 4; i++) begin
      logic eg;
      eg = 1'b0;
`ifdef MUL_ARB_RR_EN
      eg = i[0];
`endif
      chk("grant_seq", grants[i], eg);
      if (i > 0) begin
        chk("grant_spacing", 64'(gcyc[i] - last_cyc), 64'(W + 2));
        last_cyc = gcyc[i];
      end
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    for (int c = 0; c < 20; c++) tick();
    resp_ready = 1'b0;

    // Reset in the second WAIT cycle abandons the operation.
    req1_valid = 1'b1; req1_a = 32'd3; req1_b = 32'd4;
    tick();
    req1_valid = 1'b0;
    tick();
    tick();
    chk("pre_reset_busy", {busy, resp_id}, 64'b11);
    rst_n = 1'b0;
    #1;
    chk("mid_reset_status", {resp_valid, resp_id, busy}, 0);
    chk("mid_reset_prod", resp_prod, 0);
    chk("mid_reset_operands", {mul_p, mul_q}, 0);
    #2;
    rst_n = 1'b1;
    lat = 0;
    for (int c = 0; c < 20; c++) begin
      tick();
      if (resp_valid || busy) lat++;
    end
    chk("no_resp_after_reset", 64'(lat), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mul_arbiter.md
MUL_ARBITER -- requirements
Module: mul_arbiter

Interface
REQ-001 The block SHALL have parameter WAIT_CYCLES, default 4, giving the settle cycles allowed for the shared combinational multiplier; legal range 1..15.
REQ-002 The block SHALL have a single clock; reset is asynchronous and active-low.
REQ-003 clk  in  1  rising-edge clock.
REQ-004 rst_n  in  1  asynchronous active-low reset.
REQ-005 req0_valid / req1_valid  in  1  requester N has an operand pair.
REQ-006 req0_ready / req1_ready  out  1  request N is accepted on this edge when valid is also high.
REQ-007 req0_a, req0_b / req1_a, req1_b  in  32  signed two's-complement operands.
REQ-008 resp_valid  out  1  product available.
REQ-009 resp_ready  in  1  consumer takes the product.
REQ-010 resp_id  out  1  requester index of the product.
REQ-011 resp_prod  out  64  signed 64-bit product.
REQ-012 mul_p, mul_q  out  32  registered operands that drive the shared multiplier.
REQ-013 mul_y  in  64  combinational multiplier result.
REQ-014 busy  out  1  high whenever the state is not IDLE.

Function
REQ-015 The state machine SHALL have three states, IDLE, WAIT and DONE, and SHALL enter IDLE from reset.
REQ-016 In IDLE, the grant SHALL be computed combinationally every cycle, and req0_ready/req1_ready SHALL be high only for the granted port when its valid is high; both readies SHALL be low outside IDLE.
REQ-017 On accept (valid&&ready), the block SHALL latch the operands into mul_p/mul_q and the port index into resp_id, load the counter with WAIT_CYCLES, and go to WAIT.
REQ-018 In WAIT, the counter SHALL decrement each cycle; mul_p/mul_q SHALL hold stable through WAIT and DONE.
REQ-019 When the counter reaches 1 in WAIT, the next edge SHALL capture mul_y into resp_prod, set resp_valid, and go to DONE; for an accept at edge k, resp_valid rises at edge k+WAIT_CYCLES.
REQ-020 In DONE, resp_valid, resp_prod and resp_id SHALL hold until resp_valid&&resp_ready; on that edge resp_valid SHALL clear and the state SHALL return to IDLE.
REQ-021 No new request SHALL be accepted on the DONE handshake edge; the earliest next accept is the following edge, giving a throughput of one product per WAIT_CYCLES+2 cycles minimum.
REQ-022 resp_prod SHALL equal the full signed product p*q; 0x80000000*0x80000000 SHALL yield 0x4000000000000000.
REQ-023 Requester operands SHALL be don't-care after accept; requester changes after accept SHALL NOT affect the product.
REQ-024 A valid deasserted before ready SHALL be dropped silently, with no state change.

Reset
REQ-025 Assertion of rst_n low SHALL asynchronously force state=IDLE, resp_valid=0, resp_id=0, resp_prod=0, mul_p=0, mul_q=0, counter=0 and last_id=1.
REQ-026 A reset during WAIT or DONE SHALL abandon the operation, and no response SHALL be produced for it.

Configuration
REQ-027 With MUL_ARB_RR_EN defined, the arbiter SHALL be round-robin: when both valids are high, the grant goes to the port != last_id, and last_id SHALL update on each accept.
REQ-028 With MUL_ARB_RR_EN undefined, the arbiter SHALL use fixed priority with port 0 winning, and the last_id register SHALL not exist.

Verification
REQ-029 req0 a=7, b=-3, WAIT_CYCLES=4 -> resp_valid at accept+4 edges, resp_prod=0xFFFFFFFFFFFFFFEB, resp_id=0.
REQ-030 Both ports continuously valid, resp_ready=1 -> grant sequence 0,1,0,1 (RR_EN defined) or 0,0,0,0 (undefined).
REQ-031 resp_ready=0 for 10 cycles in DONE -> resp_prod, resp_id and mul_p stable; both readies low; busy=1.
REQ-032 a=b=0x80000000 -> resp_prod=0x4000000000000000; a=-1, b=-1 -> 0x0000000000000001.
REQ-033 rst_n low in WAIT cycle 2 -> all outputs at reset values immediately; no resp_valid after release.
REQ-034 req1 valid during the DONE handshake -> req1_ready low on that edge; req1 accepted the next edge.
